// File: rtl/fifo_n.sv
// fifo_n: parametrised multi-entry FIFO with occupancy count,
// almost-full flag and synchronous clear; ready gated on full/empty.
module fifo_n #(
  parameter int WIDTH    = 128,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             clear__ENA,
  output logic             clear__RDY,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             enq_x, deq_x;
  logic             wr_en;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);
  assign in_enq__RDY    = ~full;
  assign out_deq__RDY   = ~empty;
  assign out_first__RDY = ~empty;
  assign clear__RDY     = 1'b1;
  assign count          = count_q;
  assign almost_full    = (count_q >= CW'(AF_LEVEL));
  assign out_first      = empty ? '0 : mem_q[rd_ptr_q];

  assign enq_x = in_enq__ENA & ~full;
  assign deq_x = out_deq__ENA & ~empty;
  assign wr_en = enq_x & ~clear__ENA;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear__ENA) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_x) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq_x) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({enq_x, deq_x})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= in_enq_v;
    end
  end

endmodule

// File: tb/tb_fifo_n.sv
// Directed bench for fifo_n: DEPTH=4/WIDTH=128 instance plus a
// DEPTH=3/WIDTH=8 instance for non-power-of-two wrap and reset.
module tb_fifo_n;

  logic         CLK = 1'b0;
  logic         nRST;
  always #5 CLK = ~CLK;

  logic         a_enq, a_deq, a_clr;
  logic [127:0] a_v, a_first;
  logic         a_enq_rdy, a_deq_rdy, a_first_rdy, a_clr_rdy, a_af;
  logic [2:0]   a_cnt;

  logic         b_enq, b_deq, b_clr;
  logic [7:0]   b_v, b_first;
  logic         b_enq_rdy, b_deq_rdy, b_first_rdy, b_clr_rdy, b_af;
  logic [1:0]   b_cnt;

  int checks = 0;
  int errors = 0;

  fifo_n #(.WIDTH(128), .DEPTH(4)) dut_a (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(a_enq), .in_enq_v(a_v), .in_enq__RDY(a_enq_rdy),
    .out_deq__ENA(a_deq), .out_deq__RDY(a_deq_rdy),
    .out_first(a_first), .out_first__RDY(a_first_rdy),
    .clear__ENA(a_clr), .clear__RDY(a_clr_rdy),
    .count(a_cnt), .almost_full(a_af)
  );

  fifo_n #(.WIDTH(8), .DEPTH(3)) dut_b (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(b_enq), .in_enq_v(b_v), .in_enq__RDY(b_enq_rdy),
    .out_deq__ENA(b_deq), .out_deq__RDY(b_deq_rdy),
    .out_first(b_first), .out_first__RDY(b_first_rdy),
    .clear__ENA(b_clr), .clear__RDY(b_clr_rdy),
    .count(b_cnt), .almost_full(b_af)
  );

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] fv [4];
  logic [7:0] cv [4];

  initial begin
    fv = '{8'h11, 8'h22, 8'h33, 8'h44};
    cv = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    nRST = 1'b0;
    a_enq = 0; a_deq = 0; a_clr = 0; a_v = '0;
    b_enq = 0; b_deq = 0; b_clr = 0; b_v = '0;
    tick();
    tick();
    nRST = 1'b1;

    chk("rst_cnt", 128'(a_cnt), 128'd0);
    chk("rst_enq_rdy", 128'(a_enq_rdy), 128'd1);
    chk("rst_deq_rdy", 128'(a_deq_rdy), 128'd0);
    chk("rst_first_rdy", 128'(a_first_rdy), 128'd0);
    chk("rst_first", a_first, 128'd0);
    chk("rst_af", 128'(a_af), 128'd0);
    chk("clr_rdy_a", 128'(a_clr_rdy), 128'd1);
    chk("clr_rdy_b", 128'(b_clr_rdy), 128'd1);

    for (int i = 0; i < 4; i++) begin
      a_enq = 1; a_v = rep(fv[i]);
      tick();
      chk("fill_cnt", 128'(a_cnt), 128'(i + 1));
      chk("fill_head", a_first, rep(8'h11));
      chk("fill_af", 128'(a_af), 128'(i >= 2));
    end
    chk("full_enq_rdy", 128'(a_enq_rdy), 128'd0);
    a_v = rep(8'h55);
    tick();
    a_enq = 0;
    chk("full_ignore_cnt", 128'(a_cnt), 128'd4);

    for (int i = 0; i < 4; i++) begin
      chk("drain_head", a_first, rep(fv[i]));
      a_deq = 1;
      tick();
      a_deq = 0;
      chk("drain_cnt", 128'(a_cnt), 128'(3 - i));
    end
    chk("empty_deq_rdy", 128'(a_deq_rdy), 128'd0);
    chk("empty_first", a_first, 128'd0);

    a_enq = 1; a_v = rep(8'h01); tick();
    a_v = rep(8'h02); tick();
    a_deq = 1;
    for (int i = 0; i < 10; i++) begin
      a_v = 128'(100 + i);
      chk("sim_head", a_first,
          (i == 0) ? rep(8'h01) :
          (i == 1) ? rep(8'h02) : 128'(100 + i - 2));
      tick();
      chk("sim_cnt", 128'(a_cnt), 128'd2);
    end
    a_enq = 0;
    chk("sim_tail0", a_first, 128'd108);
    tick();
    chk("sim_tail1", a_first, 128'd109);
    tick();
    a_deq = 0;
    chk("sim_empty", 128'(a_cnt), 128'd0);

    a_enq = 1;
    for (int i = 0; i < 4; i++) begin
      a_v = rep(cv[i]);
      tick();
    end
    chk("cont_full", 128'(a_cnt), 128'd4);
    a_deq = 1; a_v = rep(8'hDD);
    tick();
    chk("cont_cnt", 128'(a_cnt), 128'd3);
    chk("cont_head", a_first, rep(8'hC1));
    a_deq = 0; a_v = rep(8'hEE);
    tick();
    a_enq = 0;
    chk("cont_refill", 128'(a_cnt), 128'd4);
    chk("cont_d0", a_first, rep(8'hC1));
    a_deq = 1; tick();
    chk("cont_d1", a_first, rep(8'hC2));
    tick();
    chk("cont_d2", a_first, rep(8'hC3));
    tick();
    chk("cont_d3", a_first, rep(8'hEE));
    tick();
    a_deq = 0;
    chk("cont_empty", 128'(a_cnt), 128'd0);

    a_enq = 1;
    a_v = rep(8'h31); tick();
    a_v = rep(8'h32); tick();
    a_v = rep(8'h33); tick();
    chk("clr_pre", 128'(a_cnt), 128'd3);
    a_clr = 1; a_deq = 1; a_v = rep(8'h99);
    tick();
    a_clr = 0; a_deq = 0;
    chk("clr_cnt", 128'(a_cnt), 128'd0);
    chk("clr_first_rdy", 128'(a_first_rdy), 128'd0);
    chk("clr_first", a_first, 128'd0);
    a_v = 128'hAB;
    tick();
    a_enq = 0;
    chk("clr_ab", a_first, 128'hAB);
    chk("clr_ab_cnt", 128'(a_cnt), 128'd1);
    a_deq = 1; tick(); a_deq = 0;

    b_enq = 1;
    b_v = 8'hA1; tick();
    b_v = 8'hA2; tick();
    chk("b_af2", 128'(b_af), 128'd1);
    b_v = 8'hA3; tick();
    b_enq = 0;
    chk("b_full_cnt", 128'(b_cnt), 128'd3);
    chk("b_full_rdy", 128'(b_enq_rdy), 128'd0);
    chk("b_full_head", 128'(b_first), 128'hA1);
    nRST = 0; tick(); nRST = 1;
    chk("b_rst_cnt", 128'(b_cnt), 128'd0);
    chk("b_rst_first", 128'(b_first), 128'd0);
    chk("b_rst_deq_rdy", 128'(b_deq_rdy), 128'd0);
    chk("b_rst_first_rdy", 128'(b_first_rdy), 128'd0);
    chk("b_rst_af", 128'(b_af), 128'd0);
    chk("b_rst_enq_rdy", 128'(b_enq_rdy), 128'd1);
    b_enq = 1;
    b_v = 8'd1; tick();
    b_v = 8'd2; tick();
    b_deq = 1;
    for (int k = 3; k <= 7; k++) begin
      b_v = 8'(k);
      chk("b_wrap_head", 128'(b_first), 128'(k - 2));
      tick();
      chk("b_wrap_cnt", 128'(b_cnt), 128'd2);
    end
    b_enq = 0;
    chk("b_tail6", 128'(b_first), 128'd6);
    tick();
    chk("b_tail7", 128'(b_first), 128'd7);
    tick();
    b_deq = 0;
    chk("b_end_cnt", 128'(b_cnt), 128'd0);
    chk("b_end_first", 128'(b_first), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
